uart_rx_core: RTL and testbench



---
 rtl/uart_rx_core_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_rx_core.sv | 111 +++++++++++
 tb/tb_uart_rx_core.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/uart_rx_core_pkg.sv
// Shared definitions for the UART receiver.
//   state_t   : receiver FSM states
//   *_LVL     : serial line levels for start bit, stop bit and idle line
package uart_rx_core_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter producing the sample strobe for the UART receiver.
// The counter restarts from 0 on clear and after every strobe, so the first
// strobe after a clear lands half a bit (half=1) or a full bit (half=0) later.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset
//   clear  in   restart the bit period (asserted on FSM state changes)
//   half   in   1: strobe after CLKS_PER_BIT/2 cycles, 0: after CLKS_PER_BIT
//   tick   out  sample strobe, combinational from the counter
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic half,
  output logic tick
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT + 1);

  // Terminal counts: the counter reads k-1 on the k-th edge after a restart.
  localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TC = CW'((HALF == 0) ? 0 : HALF - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == (half ? HALF_TC : FULL_TC));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: deserialises start / DATA_BITS data (LSB first) / stop
// frames from rx_in into data_out. DATA_BITS must be at least 2.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   rx_in      in   serial input, synchronous to clk, idle high
//   data_out   out  last correctly framed byte
//   rx_done    out  one-cycle pulse when data_out is updated
//   frame_err  out  one-cycle pulse when the stop bit samples 0
//
// state | meaning
// IDLE  | line idle, waiting for a start level
// START | start seen, re-sample at mid-bit to reject glitches
// DATA  | shifting in data bits, one per bit period
// STOP  | waiting for the stop-bit sample
// BREAK | bad stop bit, wait for the line to return high
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done,
  output logic                 frame_err
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  state_t                 state, state_nx;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   tick;
  logic                   state_chg;
  logic                   done_nx;
  logic                   err_nx;

  assign state_chg = (state_nx != state);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state_chg),
    .half  (state == START),
    .tick  (tick)
  );

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        // With no half-bit delay the detect edge already confirms the start.
        if (rx_in == START_LVL) state_nx = (HALF == 0) ? DATA : START;
      end
      START: begin
        if (tick) state_nx = (rx_in == START_LVL) ? DATA : IDLE;
      end
      DATA: begin
        if (tick && (bit_cnt == LAST_BIT)) state_nx = STOP;
      end
      STOP: begin
        if (tick) begin
          if (rx_in == STOP_LVL) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = BREAK;
            err_nx   = 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_in == IDLE_LVL) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      data_out  <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      rx_done   <= done_nx;
      frame_err <= err_nx;
      if (done_nx) data_out <= shift;
      if (state_chg) begin
        bit_cnt <= '0;
      end else if ((state == DATA) && tick) begin
        bit_cnt <= bit_cnt + BW'(1);
      end
      // LSB arrives first, so shift right and insert at the top.
      if ((state == DATA) && tick) shift <= {rx_in, shift[DATA_BITS-1:1]};
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed self-checking bench for uart_rx_core.
// dut1: CLKS_PER_BIT=1, dut2: CLKS_PER_BIT=16.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       reset1, rx1, reset2, rx2;
  logic [7:0] data_out1, data_out2;
  logic       rx_done1, frame_err1, rx_done2, frame_err2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done1 = 0, err1 = 0, done2 = 0, err2 = 0;
  int last_done1 = 0, prev_done1 = 0;
  int d0, e0;
  logic [7:0] b;

  always #5 clk = ~clk;

  uart_rx_core #(.CLKS_PER_BIT(1), .DATA_BITS(8)) dut1 (
    .clk       (clk),
    .reset     (reset1),
    .rx_in     (rx1),
    .data_out  (data_out1),
    .rx_done   (rx_done1),
    .frame_err (frame_err1)
  );

  uart_rx_core #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut2 (
    .clk       (clk),
    .reset     (reset2),
    .rx_in     (rx2),
    .data_out  (data_out2),
    .rx_done   (rx_done2),
    .frame_err (frame_err2)
  );

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    cyc++;
    if (rx_done1 === 1'b1) begin
      done1++;
      prev_done1 = last_done1;
      last_done1 = cyc;
    end
    if (frame_err1 === 1'b1) err1++;
    if (rx_done2 === 1'b1) done2++;
    if (frame_err2 === 1'b1) err2++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one bit to dut1 for one clock; return just after the sampling edge.
  task automatic tx1(input logic v);
    rx1 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic frame1(input logic [7:0] d, input logic stop);
    tx1(1'b0);
    for (int i = 0; i < 8; i++) tx1(d[i]);
    tx1(stop);
  endtask

  task automatic tx2(input logic v, input int n);
    rx2 = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rx1 = 1'b1; rx2 = 1'b1;
    reset1 = 1'b1; reset2 = 1'b1;

    // 1. Reset held with rx toggling.
    for (int i = 0; i < 6; i++) begin
      rx1 = i[0]; rx2 = i[0];
      @(posedge clk); #1;
      check("rst_data", 32'(data_out1), 32'h00);
      check("rst_done", 32'(rx_done1), 32'h0);
      check("rst_ferr", 32'(frame_err1), 32'h0);
    end
    rx1 = 1'b1; rx2 = 1'b1;
    @(posedge clk); #1;
    reset1 = 1'b0; reset2 = 1'b0;
    repeat (3) tx1(1'b1);

    // 2. Single good frame 0x7C.
    d0 = done1;
    frame1(8'h7C, 1'b1);
    check("f7c_done", 32'(rx_done1), 32'h1);
    check("f7c_data", 32'(data_out1), 32'h7C);
    tx1(1'b1);
    check("f7c_done_clr", 32'(rx_done1), 32'h0);
    check("f7c_npulse", 32'(done1 - d0), 32'd1);

    // 3. Bad stop bit, then line held low.
    d0 = done1; e0 = err1;
    frame1(8'h75, 1'b0);
    check("ferr_pulse", 32'(frame_err1), 32'h1);
    check("ferr_nodone", 32'(rx_done1), 32'h0);
    check("ferr_data", 32'(data_out1), 32'h7C);
    for (int i = 0; i < 20; i++) tx1(1'b0);
    check("brk_nerr", 32'(err1 - e0), 32'd1);
    check("brk_ndone", 32'(done1 - d0), 32'd0);
    check("brk_data", 32'(data_out1), 32'h7C);
    repeat (2) tx1(1'b1);

    // 4. Back-to-back frames 0x55, 0xA3.
    d0 = done1;
    frame1(8'h55, 1'b1);
    check("b2b_done0", 32'(rx_done1), 32'h1);
    check("b2b_data0", 32'(data_out1), 32'h55);
    frame1(8'hA3, 1'b1);
    check("b2b_done1", 32'(rx_done1), 32'h1);
    check("b2b_data1", 32'(data_out1), 32'hA3);
    tx1(1'b1);
    check("b2b_npulse", 32'(done1 - d0), 32'd2);
    check("b2b_gap", 32'(last_done1 - prev_done1), 32'd10);

    // 5. Reset after four data bits, then a clean 0x3C frame.
    d0 = done1; e0 = err1;
    b = 8'h3C;
    tx1(1'b0);
    for (int i = 0; i < 4; i++) tx1(b[i]);
    reset1 = 1'b1;
    tx1(b[4]);
    check("mid_rst_data", 32'(data_out1), 32'h00);
    check("mid_rst_done", 32'(rx_done1), 32'h0);
    tx1(b[5]);
    reset1 = 1'b0;
    repeat (3) tx1(1'b1);
    check("mid_rst_npulse", 32'(done1 - d0 + err1 - e0), 32'd0);
    frame1(8'h3C, 1'b1);
    check("f3c_done", 32'(rx_done1), 32'h1);
    check("f3c_data", 32'(data_out1), 32'h3C);
    tx1(1'b1);
    check("f3c_npulse", 32'(done1 - d0), 32'd1);
    check("f3c_nerr", 32'(err1 - e0), 32'd0);

    // 6. CLKS_PER_BIT=16: short glitch rejected, then 0xF0 frame.
    tx2(1'b0, 4);
    tx2(1'b1, 40);
    check("glitch_ndone", 32'(done2), 32'd0);
    check("glitch_nerr", 32'(err2), 32'd0);
    check("glitch_data", 32'(data_out2), 32'h00);
    b = 8'hF0;
    tx2(1'b0, 16);
    for (int i = 0; i < 8; i++) tx2(b[i], 16);
    tx2(1'b1, 16);
    tx2(1'b1, 16);
    check("ff0_data", 32'(data_out2), 32'hF0);
    check("ff0_ndone", 32'(done2), 32'd1);
    check("ff0_nerr", 32'(err2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
